// File: rtl/alu_seq.sv
// Handshaked RV32I-style integer ALU: single-cycle logic/arithmetic ops and
// iterative shifts through a barrel-step shifter, with a registered result.
module alu_seq #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1,
  parameter int unsigned SHAMT_W    = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic            out_lt,
  output logic            out_illegal,
  output logic            busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;

  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  state_e              state_q, state_d;
  logic                out_valid_d;
  logic [XLEN-1:0]     out_result_d;
  logic                out_zero_d, out_lt_d, out_illegal_d;
  logic [XLEN-1:0]     work_q, work_d;
  logic [SHAMT_W-1:0]  rem_q, rem_d;
  logic                left_q, left_d;
  logic                fill_q, fill_d;

  logic                accept;
  logic                is_shift;
  logic [SHAMT_W-1:0]  shamt;
  logic [SHAMT_W-1:0]  step_amt;
  logic [SHAMT_W-1:0]  rem_next;
  logic [XLEN-1:0]     imm_res;
  logic [XLEN-1:0]     step_res;
  logic                imm_lt;
  logic                imm_ill;

  assign in_ready = (state_q == S_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q == S_SHIFT);
  assign shamt    = in_b[SHAMT_W-1:0];
  assign is_shift = (in_op == OP_SLL) || (in_op == OP_SRL) || (in_op == OP_SRA);

  // Single-cycle result; shift ops pass in_a through for the shamt==0 case
  always_comb begin
    imm_res = '0;
    imm_lt  = 1'b0;
    imm_ill = 1'b0;
    case (in_op)
      OP_ADD:  imm_res = in_a + in_b;
      OP_SUB:  imm_res = in_a - in_b;
      OP_SLT: begin
        imm_lt  = $signed(in_a) < $signed(in_b);
        imm_res = {{(XLEN-1){1'b0}}, imm_lt};
      end
      OP_SLTU: begin
        imm_lt  = in_a < in_b;
        imm_res = {{(XLEN-1){1'b0}}, imm_lt};
      end
      OP_XOR:  imm_res = in_a ^ in_b;
      OP_OR:   imm_res = in_a | in_b;
      OP_AND:  imm_res = in_a & in_b;
      OP_SLL, OP_SRL, OP_SRA: imm_res = in_a;
      default: imm_ill = 1'b1;
    endcase
  end

  // One barrel step of at most SHIFT_STEP positions
  always_comb begin
    step_amt = (rem_q > STEP) ? STEP : rem_q;
    rem_next = rem_q - step_amt;
    if (left_q) begin
      step_res = work_q << step_amt;
    end else begin
      step_res = (work_q >> step_amt) |
                 (fill_q ? ~({XLEN{1'b1}} >> step_amt) : {XLEN{1'b0}});
    end
  end

  // Next-state and output-register logic; flush outranks completion and accept
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid;
    out_result_d  = out_result;
    out_zero_d    = out_zero;
    out_lt_d      = out_lt;
    out_illegal_d = out_illegal;
    work_d        = work_q;
    rem_d         = rem_q;
    left_d        = left_q;
    fill_d        = fill_q;

    if (flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      rem_d       = '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid_d = 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_shift && (shamt != '0)) begin
              state_d = S_SHIFT;
              work_d  = in_a;
              rem_d   = shamt;
              left_d  = (in_op == OP_SLL);
              fill_d  = (in_op == OP_SRA) && in_a[XLEN-1];
            end else begin
              out_valid_d   = 1'b1;
              out_result_d  = imm_res;
              out_zero_d    = (imm_res == '0);
              out_lt_d      = imm_lt;
              out_illegal_d = imm_ill;
            end
          end
        end
        S_SHIFT: begin
          work_d = step_res;
          rem_d  = rem_next;
          if (rem_next == '0) begin
            state_d       = S_IDLE;
            out_valid_d   = 1'b1;
            out_result_d  = step_res;
            out_zero_d    = (step_res == '0);
            out_lt_d      = 1'b0;
            out_illegal_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_zero    <= 1'b0;
      out_lt      <= 1'b0;
      out_illegal <= 1'b0;
      work_q      <= '0;
      rem_q       <= '0;
      left_q      <= 1'b0;
      fill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid   <= out_valid_d;
      out_result  <= out_result_d;
      out_zero    <= out_zero_d;
      out_lt      <= out_lt_d;
      out_illegal <= out_illegal_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      left_q      <= left_d;
      fill_q      <= fill_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: instance 0 uses SHIFT_STEP=1, instance 1 SHIFT_STEP=4.
module tb_alu_seq;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        lt;
    logic        ill;
    int          lat;
    int          t_acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  out_zero, out_lt, out_illegal, busy;
  logic [3:0]  in_op [2];
  logic [31:0] in_a [2];
  logic [31:0] in_b [2];
  logic [31:0] out_result [2];

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy[0]) busy_cnt <= busy_cnt + 1;

  alu_seq #(.XLEN(32), .SHIFT_STEP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_op(in_op[0]),
    .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(out_result[0]),
    .out_zero(out_zero[0]), .out_lt(out_lt[0]), .out_illegal(out_illegal[0]),
    .busy(busy[0])
  );

  alu_seq #(.XLEN(32), .SHIFT_STEP(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_op(in_op[1]),
    .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(out_result[1]),
    .out_zero(out_zero[1]), .out_lt(out_lt[1]), .out_illegal(out_illegal[1]),
    .busy(busy[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop the expected response whenever a result is handed off
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (out_valid[d] && out_ready[d]) begin
          exp_t e;
          bit   got;
          got = 1'b0;
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          if (got) begin
            chk($sformatf("result_dut%0d{ill,lt,zero,res}", d),
                64'({out_illegal[d], out_lt[d], out_zero[d], out_result[d]}),
                64'({e.ill, e.lt, e.zero, e.res}));
            if (e.lat != 0)
              chk($sformatf("latency_dut%0d", d), 64'(cyc - e.t_acc), 64'(e.lat));
          end else begin
            checks++;
            errors++;
            $display("FAIL unexpected_result_dut%0d: got %0h expected none", d, out_result[d]);
          end
        end
      end
    end
  end

  // Offer one op (called at posedge+1); returns at posedge+1 after the accept edge
  task automatic issue(input int d, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r, input logic lt,
                       input logic ill, input int lat, input bit push);
    int   n;
    exp_t e;
    in_op[d] = op;
    in_a[d]  = a;
    in_b[d]  = b;
    in_valid[d] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_dut%0d: in_ready 0 expected 1", d);
    end else if (push) begin
      e.res = r; e.zero = (r == 32'd0); e.lt = lt; e.ill = ill;
      e.lat = lat; e.t_acc = cyc;
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    @(negedge clk);
    while ((out_valid[d] || busy[d]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_dut%0d{valid,busy}", d), 64'({out_valid[d], busy[d]}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b0;
    rst_n = 1'b0;
    flush = 2'b00;
    in_valid = 2'b00;
    out_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      in_op[d] = 4'd0; in_a[d] = 32'd0; in_b[d] = 32'd0;
    end
    repeat (2) @(negedge clk);
    chk("reset_dut0", 64'({out_valid[0], busy[0], out_zero[0], out_lt[0], out_illegal[0], out_result[0]}), 64'(0));
    chk("reset_dut1", 64'({out_valid[1], busy[1], out_zero[1], out_lt[1], out_illegal[1], out_result[1]}), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", 64'(in_ready), 64'(2'b11));
    @(posedge clk); #1;

    // Single-cycle ops, back to back
    issue(0, 4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b0, 1, 1);
    issue(0, 4'd3, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b1, 1'b0, 1, 1);
    issue(0, 4'd4, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0,         1'b0, 1'b0, 1, 1);
    issue(0, 4'd3, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0,         1'b0, 1'b0, 1, 1);
    issue(0, 4'd4, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1,         1'b1, 1'b0, 1, 1);
    issue(0, 4'd1, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1);
    issue(0, 4'd5, 32'hF0,        32'hFF,        32'h0F,        1'b0, 1'b0, 1, 1);
    issue(0, 4'd8, 32'hA0,        32'h0B,        32'hAB,        1'b0, 1'b0, 1, 1);
    issue(0, 4'd9, 32'hFF00,      32'h0FF0,      32'h0F00,      1'b0, 1'b0, 1, 1);
    issue(0, 4'd2, 32'h1234,      32'h0,         32'h1234,      1'b0, 1'b0, 1, 1);
    chk("sll0_busy", 64'(busy[0]), 64'(0));
    issue(0, 4'd12, 32'h1234,     32'h5,         32'h0,         1'b0, 1'b1, 1, 1);
    issue(0, 4'd15, 32'hFFFF,     32'hFFFF,      32'h0,         1'b0, 1'b1, 1, 1);

    // Iterative shifts
    wait_idle(0);
    @(posedge clk); #1;
    b0 = busy_cnt;
    issue(0, 4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 1);
    wait_idle(0);
    chk("sra31_busy_cycles", 64'(busy_cnt - b0), 64'(31));
    @(posedge clk); #1;
    issue(0, 4'd7, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1'b0, 1'b0, 5, 1);
    issue(0, 4'd6, 32'hF000_0000, 32'd4,  32'h0F00_0000, 1'b0, 1'b0, 5, 1);
    issue(0, 4'd2, 32'h1,         32'h23, 32'h8,         1'b0, 1'b0, 4, 1);
    issue(0, 4'd2, 32'h1,         32'd31, 32'h8000_0000, 1'b0, 1'b0, 32, 1);
    issue(0, 4'd7, 32'h4000_0000, 32'd30, 32'h1,         1'b0, 1'b0, 31, 1);
    wait_idle(0);

    // Backpressure, then consume-and-accept in the same cycle
    @(posedge clk); #1 out_ready[0] = 1'b0;
    issue(0, 4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 0, 1);
    @(negedge clk);
    chk("hold1{valid,zero,in_ready,res}", 64'({out_valid[0], out_zero[0], in_ready[0], out_result[0]}), 64'({1'b1, 1'b0, 1'b0, 32'd12}));
    @(negedge clk);
    chk("hold2{valid,zero,in_ready,res}", 64'({out_valid[0], out_zero[0], in_ready[0], out_result[0]}), 64'({1'b1, 1'b0, 1'b0, 32'd12}));
    @(posedge clk); #1 out_ready[0] = 1'b1;
    issue(0, 4'd5, 32'hF0, 32'hFF, 32'h0F, 1'b0, 1'b0, 1, 1);
    wait_idle(0);

    // Flush mid-shift
    @(posedge clk); #1;
    issue(0, 4'd6, 32'hFFFF_FFFF, 32'd20, 32'h0, 1'b0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1 flush[0] = 1'b1;
    @(posedge clk); #1 flush[0] = 1'b0;
    @(negedge clk);
    chk("after_flush{valid,busy,in_ready}", 64'({out_valid[0], busy[0], in_ready[0]}), 64'(3'b001));
    repeat (30) @(negedge clk);
    chk("flush_quiet{valid,busy}", 64'({out_valid[0], busy[0]}), 64'(0));

    // Reset mid-shift
    @(posedge clk); #1;
    issue(0, 4'd6, 32'hFFFF_FFFF, 32'd20, 32'h0, 1'b0, 1'b0, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("in_reset{valid,busy,res}", 64'({out_valid[0], busy[0], out_result[0]}), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset{valid,busy,in_ready}", 64'({out_valid[0], busy[0], in_ready[0]}), 64'(3'b001));
    repeat (30) @(negedge clk);
    chk("reset_quiet{valid,busy}", 64'({out_valid[0], busy[0]}), 64'(0));
    @(posedge clk); #1;
    issue(0, 4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1, 1);
    wait_idle(0);

    // SHIFT_STEP=4 instance
    @(posedge clk); #1;
    issue(1, 4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 9, 1);
    issue(1, 4'd6, 32'h80,        32'd5,  32'h4,         1'b0, 1'b0, 3, 1);
    issue(1, 4'd2, 32'h3,         32'd8,  32'h300,       1'b0, 1'b0, 3, 1);
    issue(1, 4'd7, 32'hF000_0000, 32'd4,  32'hFF00_0000, 1'b0, 1'b0, 2, 1);
    issue(1, 4'd0, 32'd2,         32'd2,  32'd4,         1'b0, 1'b0, 1, 1);
    wait_idle(1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q0.size() + q1.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
